// File: rtl/resta_c2_seq.sv
// rtl/resta_c2_seq.sv - multi-cycle two's-complement subtractor, CHUNK bits per clock, LSB first
module resta_c2_seq #(
    parameter int ANCHO = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ANCHO-1:0] a,
    input  logic [ANCHO-1:0] b,
    input  logic             bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ANCHO-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int N  = ANCHO / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if ((CHUNK < 1) || ((ANCHO % CHUNK) != 0)) begin : g_bad_chunk
            $error("resta_c2_seq: ANCHO must be an integer multiple of CHUNK");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [ANCHO-1:0] a_q, a_d;
    logic [ANCHO-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [ANCHO-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    int               base;
    logic [CHUNK-1:0] a_k, b_k;
    logic [CHUNK:0]   sum_w;
    logic             last;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        d_d     = d_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        base  = int'(cnt_q) * CHUNK;
        a_k   = a_q[base +: CHUNK];
        b_k   = b_q[base +: CHUNK];
        // Subtraction as a + ~b + ~bi: the carry chain is an inverted borrow chain.
        sum_w = {1'b0, a_k} + {1'b0, ~b_k} + (CHUNK+1)'(carry_q);
        last  = (cnt_q == CW'(N - 1));

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = ~bi;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                d_d[base +: CHUNK] = sum_w[CHUNK-1:0];
                carry_d            = sum_w[CHUNK];
                cnt_d              = cnt_q + 1'b1;
                if (last) begin
                    bout_d  = ~sum_w[CHUNK];
                    ovf_d   = (a_q[ANCHO-1] != b_q[ANCHO-1]) &&
                              (sum_w[CHUNK-1] != a_q[ANCHO-1]);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign d         = d_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_resta_c2_seq.sv
// tb/tb_resta_c2_seq.sv - self-checking bench for resta_c2_seq (CHUNK=16 and CHUNK=64 instances)
module tb_resta_c2_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv[2], ir[2], ibi[2], ov[2], ordy[2], bo[2], of[2];
    logic [63:0] ia[2], ib[2], od[2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    resta_c2_seq #(.ANCHO(64), .CHUNK(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(ia[0]), .b(ib[0]), .bi(ibi[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .d(od[0]), .bout(bo[0]), .ovf(of[0])
    );

    resta_c2_seq #(.ANCHO(64), .CHUNK(64)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(ia[1]), .b(ib[1]), .bi(ibi[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .d(od[1]), .bout(bo[1]), .ovf(of[1])
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        bi;
        logic [63:0] d;
        logic        bout;
        logic        ovf;
        string       nm;
    } vec_t;

    // Reference: plain wide arithmetic; returns {ovf, bout, d}.
    function automatic logic [65:0] model(input logic [63:0] x, input logic [63:0] y, input logic c);
        logic [64:0] u;
        logic [65:0] s;
        logic        o;
        u = {1'b0, x} - {1'b0, y} - 65'(c);
        s = {{2{x[63]}}, x} - {{2{y[63]}}, y} - 66'(c);
        o = (s[65:63] != 3'b000) && (s[65:63] != 3'b111);
        return {o, u[64], u[63:0]};
    endfunction

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input int u, input string nm);
        int n = 0;
        while (!ir[u] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " in_ready timeout"}, 66'(ir[u]), 66'd1);
    endtask

    task automatic do_op(input int u, input logic [63:0] x, input logic [63:0] y, input logic c,
                         input logic [63:0] ed, input logic eb, input logic eo,
                         input int el, input string nm);
        int lat = 0;
        int low = 0;
        wait_ready(u, nm);
        ia[u] = x; ib[u] = y; ibi[u] = c; iv[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[u] = 1'b0;
        ia[u] = {$urandom, $urandom};
        ib[u] = {$urandom, $urandom};
        ibi[u] = 1'($urandom);
        while (!ov[u] && lat < 50) begin
            if (!ir[u]) low++;
            @(negedge clk);
            lat++;
        end
        if (!ir[u]) low++;
        chk({nm, " latency"}, 66'(lat), 66'(el));
        chk({nm, " in_ready low cycles"}, 66'(low), 66'(el + 1));
        chk({nm, " d"}, 66'(od[u]), 66'(ed));
        chk({nm, " bout"}, 66'(bo[u]), 66'(eb));
        chk({nm, " ovf"}, 66'(of[u]), 66'(eo));
        @(negedge clk);
        chk({nm, " out_valid one cycle"}, 66'(ov[u]), 66'd0);
        chk({nm, " in_ready back"}, 66'(ir[u]), 66'd1);
    endtask

    vec_t tbl[7];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [65:0] m;
        logic [63:0] x, y;
        logic        cb;
        int          n;

        tbl[0] = '{64'h0, 64'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, "borrow_from_zero"};
        tbl[1] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, "signed_ovf"};
        tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0, 1'b0, 1'b0, "equal_ops"};
        tbl[3] = '{64'h5, 64'h3, 1'b1, 64'h1, 1'b0, 1'b0, "five_three_bi"};
        tbl[4] = '{64'h0, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, "zero_zero_bi"};
        tbl[5] = '{64'h0001_0000_0000_0000, 64'h1, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0, "cross_chunk"};
        tbl[6] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1, "pos_minus_neg"};

        for (int u = 0; u < 2; u++) begin
            iv[u] = 1'b0; ia[u] = '0; ib[u] = '0; ibi[u] = 1'b0; ordy[u] = 1'b1;
        end

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("reset in_ready", 66'(ir[u]), 66'd1);
            chk("reset out_valid", 66'(ov[u]), 66'd0);
            chk("reset d", 66'(od[u]), 66'd0);
            chk("reset bout", 66'(bo[u]), 66'd0);
            chk("reset ovf", 66'(of[u]), 66'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table on both chunk sizes
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 7; i++) begin
                do_op(u, tbl[i].a, tbl[i].b, tbl[i].bi, tbl[i].d, tbl[i].bout, tbl[i].ovf,
                      (u == 0) ? 4 : 1, tbl[i].nm);
            end
        end

        // Randomized against the reference model
        for (int i = 0; i < 24; i++) begin
            x = {$urandom, $urandom};
            y = (i % 4 == 2) ? x : {$urandom, $urandom};
            if (i % 6 == 5) y[63] = ~x[63];
            cb = 1'($urandom);
            m = model(x, y, cb);
            do_op(i % 2, x, y, cb, m[63:0], m[64], m[65], (i % 2 == 0) ? 4 : 1, "random");
        end

        // Back-pressure: result held, new operands ignored
        ordy[0] = 1'b0;
        x = 64'h1234_5678_9ABC_DEF0;
        y = 64'h0FED_CBA9_8765_4321;
        m = model(x, y, 1'b1);
        wait_ready(0, "bp");
        ia[0] = x; ib[0] = y; ibi[0] = 1'b1; iv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        n = 0;
        while (!ov[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            chk("bp out_valid held", 66'(ov[0]), 66'd1);
            chk("bp in_ready low", 66'(ir[0]), 66'd0);
            chk("bp d stable", 66'(od[0]), 66'(m[63:0]));
            chk("bp bout stable", 66'(bo[0]), 66'(m[64]));
            chk("bp ovf stable", 66'(of[0]), 66'(m[65]));
            iv[0] = 1'b1; ia[0] = {$urandom, $urandom}; ib[0] = {$urandom, $urandom};
            @(negedge clk);
        end
        ordy[0] = 1'b1;
        @(negedge clk);
        chk("bp release out_valid", 66'(ov[0]), 66'd0);
        chk("bp release in_ready", 66'(ir[0]), 66'd1);
        iv[0] = 1'b0;
        @(negedge clk);
        chk("bp in_valid in DONE not accepted", 66'(ir[0]), 66'd1);

        // Asynchronous reset two cycles into CALC
        wait_ready(0, "rst");
        ia[0] = 64'hDEAD_BEEF_0000_0001; ib[0] = 64'h2; ibi[0] = 1'b0; iv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 66'(ov[0]), 66'd0);
        chk("midrst d", 66'(od[0]), 66'd0);
        chk("midrst in_ready", 66'(ir[0]), 66'd1);
        chk("midrst bout", 66'(bo[0]), 66'd0);
        chk("midrst ovf", 66'(of[0]), 66'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ov[0] || !ir[0]) n++;
        end
        chk("midrst no stale result", 66'(n), 66'd0);
        do_op(0, tbl[5].a, tbl[5].b, tbl[5].bi, tbl[5].d, tbl[5].bout, tbl[5].ovf, 4, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/resta_c2_seq.md
Name: resta_c2_seq

Overview:
- Multi-cycle two's-complement subtractor; the inverse datapath of the team's SumaC2 adder.
- Computes d = a - b - bi as a + ~b + ~bi, processing CHUNK bits per clock, LSB chunk first.
- Uses a valid/ready handshake on both input and output.
- Used in the ALU path wherever a full-width single-cycle borrow chain does not meet timing.

Parameters:
- ANCHO, 64, operand and result width in bits.
- CHUNK, 16, bits processed per cycle. ANCHO must be an integer multiple of CHUNK; otherwise it is an elaboration error.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b, bi are valid.
- in_ready  output  1  block can accept operands.
- a  input  ANCHO  minuend.
- b  input  ANCHO  subtrahend.
- bi  input  1  borrow in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- d  output  ANCHO  difference a - b - bi, modulo 2^ANCHO.
- bout  output  1  borrow out: 1 iff unsigned a < b + bi.
- ovf  output  1  signed overflow of the subtraction.

Behaviour:
- Reset: asynchronous, active low; may assert in any state.
  - Effect: state=IDLE, in_ready=1, out_valid=0, d=0, bout=0, ovf=0.
  - Internal operand registers, chunk counter and carry are cleared.
  - Any operation in progress is aborted with no output.
- N = ANCHO/CHUNK.
- IDLE:
  - in_ready=1.
  - On in_valid at a rising edge: latch a, b, bi; carry <= ~bi; counter <= 0; go to CALC.
- CALC:
  - in_ready=0.
  - Each cycle: {c, s} = a[k] + ~b[k] + carry, where k = counter chunk slice.
  - Write d[k] <= s; carry <= c; counter++.
  - At the edge processing chunk N-1: bout <= ~c_final; ovf <= (a_msb != b_msb) & (s_msb != a_msb); go to DONE.
- DONE:
  - out_valid=1; d, bout and ovf are held stable.
  - in_ready=0; in_valid is ignored.
  - On out_ready at a rising edge: out_valid <= 0, go to IDLE.
  - If in_valid is also high in that cycle, it is not accepted; the next acceptance occurs no earlier than the following cycle.
- Latency:
  - Operands are accepted at edge T; out_valid rises after edge T+N.
  - Minimum initiation interval is N+2 cycles.
  - CHUNK=ANCHO gives out_valid after edge T+1.
- d may show partial chunks during CALC; it is valid only while out_valid=1.
- Overflow and borrow:
  - Arithmetic wraps modulo 2^ANCHO.
  - bout follows the unsigned interpretation; ovf follows the signed interpretation.
  - Both are computed over the full a - b - bi, including bi.
- out_ready held high continuously: each result is visible for exactly one cycle.
- in_valid during CALC or DONE has no effect; the operand latch is not disturbed.

Test Plan (ANCHO=64, CHUNK=16 unless noted):
- Borrow from zero:
  - Stimulus: a=0, b=1, bi=0, out_ready=1.
  - Response: out_valid rises 4 edges after acceptance; d=FFFF_FFFF_FFFF_FFFF, bout=1, ovf=0; in_ready=0 for exactly 5 cycles.
- Signed overflow:
  - Stimulus: a=8000_0000_0000_0000, b=1, bi=0.
  - Response: d=7FFF_FFFF_FFFF_FFFF, bout=0, ovf=1.
- Equal operands and borrow-in:
  - Stimulus 1: a=b=FFFF_FFFF_FFFF_FFFF, bi=0 -> d=0, bout=0, ovf=0.
  - Stimulus 2: a=5, b=3, bi=1 -> d=1, bout=0, ovf=0.
  - Stimulus 3: a=0, b=0, bi=1 -> d=all ones, bout=1.
- Cross-chunk borrow:
  - Stimulus: a=0001_0000_0000_0000, b=1.
  - Response: d=0000_FFFF_FFFF_FFFF, bout=0; exercises carry propagation through all 4 chunks.
- Back-pressure:
  - Stimulus: out_ready=0 for 5 cycles after out_valid rises; pulse in_valid with new operands meanwhile.
  - Response: d, bout and ovf are stable; in_ready=0; the new operands are ignored; one cycle after out_ready=1, in_ready=1.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously 2 cycles into CALC, then release.
  - Response: immediately out_valid=0, d=0, in_ready=1; no stale result appears; the next operation completes correctly.
  - Repeat with CHUNK=64 to check 1-cycle latency.
